sha256_block_ctrl: RTL and testbench
====================================

// Module: sha256_block_ctrl
// PURPOSE
// Avalon-MM slave controller sitting between the HPS lightweight bridge and one SHA-256 compression core.
// Software loads a 512-bit block into the 16-word buffer, starts the core and polls or takes an IRQ.
// The block sequences start/done with the core, carries the chaining state across blocks, latches the digest,
// and guards against a hung core with a watchdog.
// PARAMETERS
// TIMEOUT_CYCLES  1024  max cycles from core_start to core_done before ERR; counter width $clog2(TIMEOUT_CYCLES+1)
// CNT_W           32    width of BLOCK_CNT register (wraps 2^CNT_W-1 -> 0)
// PORTS
// clk            in   1    system clock (clk_clk domain, 50 MHz)
// reset          in   1    asynchronous, active-high reset
// avs_address    in   5    word address (register map below)
// avs_write      in   1    write strobe, no waitrequest; accepted every cycle
// avs_writedata  in   32   write data
// avs_read       in   1    read strobe; fixed read latency 1
// avs_readdata   out  32   registered read data, valid the cycle after avs_read
// irq            out  1    level interrupt = IRQ_EN & (DONE | ERR)
// core_start     out  1    one-cycle pulse: compress core_block
// core_init      out  1    held with core_start: 1 = chain from IV, 0 = chain from previous digest
// core_block     out  512  W0 at [511:480] ... W15 at [31:0]; stable from core_start until core_done/abort
// core_done      in   1    one-cycle pulse from core; core_digest valid this cycle
// core_digest    in   256  H0 at [255:224] ... H7 at [31:0]
// BEHAVIOUR
// Register map: 0x00-0x0F MSG W0..W15 (RW); 0x10 CTRL (bit0 START W1 self-clearing, bit1 INIT sticky, bit2 IRQ_EN);
//   0x11 STATUS (bit0 BUSY RO, bit1 DONE W1C, bit2 ERR W1C); 0x12-0x19 DIGEST H0..H7 (RO);
//   0x1A BLOCK_CNT (RO; write any value clears to 0); other addresses read 0, writes ignored.
// Reset: state IDLE; MSG, DIGEST, BLOCK_CNT, STATUS, CTRL = 0; avs_readdata=0, irq=0, core_start=0, core_init=0.
// FSM: IDLE -> START on CTRL write with bit0=1; START (1 cycle, core_start=1, core_init=INIT) -> WAIT;
//   WAIT -> CAPTURE on core_done; WAIT -> IDLE on timeout (sets ERR, no digest update);
//   CAPTURE (1 cycle) latches core_digest into DIGEST, sets DONE, BLOCK_CNT++, clears INIT -> IDLE.
// BUSY = (state != IDLE). START-to-CAPTURE latency = core latency + 2 cycles; DONE visible the cycle after CAPTURE.
// Timeout counter loads 0 in START, increments each WAIT cycle; reaching TIMEOUT_CYCLES exits WAIT.
// core_done arriving in the same cycle the counter reaches TIMEOUT_CYCLES: done wins, no ERR.
// core_done while IDLE or START is ignored (no state/register change).
// While BUSY: MSG writes and START writes are dropped and set ERR; CTRL bits 1/2, STATUS W1C, reads all proceed.
// W1C on DONE in the same cycle CAPTURE sets it: set wins (DONE stays 1). Same rule for ERR.
// Readdata is registered from the state at the avs_read cycle; a read of STATUS in CAPTURE returns DONE=0.
// Reset asserted mid-WAIT: immediate return to IDLE, all registers to reset values; a later core_done is ignored.
// INIT auto-clears after each successful block so consecutive blocks chain; software sets INIT for each new message.
// TESTING
// "abc" padded block, INIT=1, START, model core -> DONE=1, DIGEST H0=0xBA7816BF, H7=0xF20015AD, BLOCK_CNT=1.
// 448-bit "abcdbcdecdefdefg...nopq": block1 INIT=1, block2 INIT=0 -> H0=0x248D6A61, H7=0x19DB06C1, BLOCK_CNT=2, core_init 1 then 0.
// TIMEOUT_CYCLES=16, core never returns done -> ERR=1 exactly 16 WAIT cycles after START, BUSY=0, DIGEST unchanged, irq=1 if IRQ_EN.
// Write W3=0xDEADBEEF and START while BUSY -> ERR=1, W3 and core_block unchanged, single core_start pulse seen.
// W1C DONE in CAPTURE cycle -> DONE reads 1 afterwards; next W1C clears it and irq drops next cycle.
// Assert reset during WAIT, then pulse core_done -> all outputs/registers 0, state IDLE, no DONE, BLOCK_CNT=0.

Source files
------------

// File: rtl/sha256_block_ctrl.sv
// Avalon-MM register front end for one SHA-256 compression core: message buffer,
// start/done sequencing, chaining control, digest capture and a hung-core watchdog.
module sha256_block_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [4:0]   avs_address,
   input  logic         avs_write,
   input  logic [31:0]  avs_writedata,
   input  logic         avs_read,
   output logic [31:0]  avs_readdata,
   output logic         irq,
   output logic         core_start,
   output logic         core_init,
   output logic [511:0] core_block,
   input  logic         core_done,
   input  logic [255:0] core_digest
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

   localparam logic [4:0] ADDR_CTRL   = 5'h10;
   localparam logic [4:0] ADDR_STATUS = 5'h11;
   localparam logic [4:0] ADDR_CNT    = 5'h1A;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CAPTURE
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      msg    [16];
   logic [31:0]      digest [8];
   logic [CNT_W-1:0] block_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_inc;
   logic             init, irq_en, done, err;

   logic             busy, wr_msg, wr_ctrl, wr_status, wr_cnt, start_req;
   logic             timeout, err_set;
   logic [3:0]       dig_off;
   logic [31:0]      rd_data;

   always_comb begin
      busy      = (state != S_IDLE);
      wr_msg    = avs_write && !avs_address[4];
      wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
      wr_status = avs_write && (avs_address == ADDR_STATUS);
      wr_cnt    = avs_write && (avs_address == ADDR_CNT);
      start_req = wr_ctrl && avs_writedata[0];
      tmo_inc   = tmo_cnt + TMO_W'(1);
      // The last permitted WAIT cycle still accepts core_done; timeout only if it is absent.
      timeout   = (state == S_WAIT) && (tmo_inc == TMO_LAST) && !core_done;
      err_set   = timeout || (busy && (wr_msg || start_req));
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      core_start = 1'b0;
      core_init  = 1'b0;
      case (state)
         S_IDLE:    if (start_req) state_nxt = S_START;
         S_START: begin
            core_start = 1'b1;
            core_init  = init;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (core_done)    state_nxt = S_CAPTURE;
            else if (timeout) state_nxt = S_IDLE;
         end
         S_CAPTURE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      core_block = '0;
      for (int i = 0; i < 16; i++) core_block[511-32*i -: 32] = msg[i];
   end

   assign irq = irq_en & (done | err);

   // NOTE: the message buffer is register storage with a defined reset value, so it is cleared in the reset branch like any flop.
   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         tmo_cnt   <= '0;
         init      <= 1'b0;
         irq_en    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         block_cnt <= '0;
         for (int i = 0; i < 16; i++) msg[i] <= '0;
         for (int i = 0; i < 8; i++) digest[i] <= '0;
      end else begin
         state <= state_nxt;

         if (state == S_START)     tmo_cnt <= '0;
         else if (state == S_WAIT) tmo_cnt <= tmo_inc;

         if (wr_msg && !busy) msg[avs_address[3:0]] <= avs_writedata;

         if (wr_ctrl) begin
            init   <= avs_writedata[1];
            irq_en <= avs_writedata[2];
         end else if (state == S_CAPTURE) begin
            init <= 1'b0;
         end

         // Hardware set takes priority over a same-cycle software clear.
         if (state == S_CAPTURE)                  done <= 1'b1;
         else if (wr_status && avs_writedata[1])  done <= 1'b0;

         if (err_set)                             err <= 1'b1;
         else if (wr_status && avs_writedata[2])  err <= 1'b0;

         if (wr_cnt)                  block_cnt <= '0;
         else if (state == S_CAPTURE) block_cnt <= block_cnt + CNT_W'(1);

         if (state == S_CAPTURE)
            for (int i = 0; i < 8; i++) digest[i] <= core_digest[255-32*i -: 32];
      end
   end

   always_comb begin
      rd_data = '0;
      dig_off = avs_address[3:0] - 4'd2;
      if (!avs_address[4]) begin
         rd_data = msg[avs_address[3:0]];
      end else begin
         case (avs_address[3:0])
            4'h0: rd_data = {29'd0, irq_en, init, 1'b0};
            4'h1: rd_data = {29'd0, err, done, busy};
            4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'h9: rd_data = digest[dig_off[2:0]];
            4'hA: rd_data = 32'(block_cnt);
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         avs_readdata <= '0;
      else if (avs_read) avs_readdata <= rd_data;
   end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Bench for sha256_block_ctrl: a behavioural SHA-256 core answers core_start, and
// software-style register sequences are checked against digests computed in the bench.
module tb_sha256_block_ctrl;

   localparam int TMO = 16;

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         reset;
   logic [4:0]   avs_address;
   logic         avs_write;
   logic [31:0]  avs_writedata;
   logic         avs_read;
   logic [31:0]  avs_readdata;
   logic         irq;
   logic         core_start;
   logic         core_init;
   logic [511:0] core_block;
   logic         core_done;
   logic [255:0] core_digest;

   logic         mdl_done   = 1'b0;
   logic         inj_done   = 1'b0;
   logic [255:0] mdl_digest = '0;
   logic [255:0] inj_digest = '0;

   assign core_done   = mdl_done | inj_done;
   assign core_digest = inj_done ? inj_digest : mdl_digest;

   sha256_block_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .avs_address  (avs_address),
      .avs_write    (avs_write),
      .avs_writedata(avs_writedata),
      .avs_read     (avs_read),
      .avs_readdata (avs_readdata),
      .irq          (irq),
      .core_start   (core_start),
      .core_init    (core_init),
      .core_block   (core_block),
      .core_done    (core_done),
      .core_digest  (core_digest)
   );

   always #10 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- SHA-256 reference ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_comp(input logic [255:0] h_in, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) +
                w[i-7]  + (ror(w[i-2], 17) ^ ror(w[i-2], 19)  ^ (w[i-2] >> 10));
      {a, b, c, d, e, f, g, h} = h_in;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
              h_in[127:96]  + e, h_in[95:64]    + f, h_in[63:32]    + g, h_in[31:0]     + h};
   endfunction

   // ---------------- behavioural core ----------------
   int           core_lat   = 4;
   bit           core_hang  = 1'b0;
   int           start_seen = 0;
   bit           init_log [$];
   logic [255:0] core_h = '0;
   logic [511:0] core_blk;
   logic         core_ini;

   initial begin
      forever begin
         @(negedge clk);
         if (core_start === 1'b1) begin
            core_blk = core_block;
            core_ini = core_init;
            start_seen++;
            init_log.push_back(core_ini);
            if (!core_hang) begin
               core_h = sha_comp(core_ini ? IV : core_h, core_blk);
               repeat (core_lat) @(posedge clk);
               #1 mdl_done = 1'b1;
               mdl_digest  = core_h;
               @(posedge clk);
               #1 mdl_done = 1'b0;
            end
         end
      end
   end

   // ---------------- bus helpers (called at a falling edge) ----------------
   logic [31:0]  cur_msg [16];
   logic [255:0] exp_h;
   int           exp_cnt;

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(tag, 64'(d), 64'(exp));
   endtask

   function automatic logic [511:0] blk_of();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = cur_msg[i];
      return b;
   endfunction

   task automatic load_msg();
      for (int i = 0; i < 16; i++) bus_wr(5'(i), cur_msg[i]);
   endtask

   task automatic start_blk(input bit ini);
      bus_wr(5'h10, {29'd0, 1'b1, ini, 1'b1});
   endtask

   task automatic clr_status();
      bus_wr(5'h11, 32'h6);
   endtask

   task automatic wait_irq(input int max, output int k);
      k = 0;
      while (irq !== 1'b1 && k < max) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_done(input string tag, input int max);
      logic [31:0] s;
      int n = 0;
      do begin
         bus_rd(5'h11, s);
         n++;
      end while (!s[1] && n < max);
      check(tag, 64'(s[1]), 64'd1);
   endtask

   task automatic chk_digest(input string tag, input logic [255:0] exp);
      for (int i = 0; i < 8; i++)
         rd_chk($sformatf("%s H%0d", tag, i), 5'(8'h12 + i), exp[255-32*i -: 32]);
   endtask

   task automatic run_ok(input string tag, input bit ini, input int lat);
      int k;
      core_lat = lat;
      clr_status();
      load_msg();
      start_blk(ini);
      wait_irq(lat + 20, k);
      check({tag, " latency"}, 64'(k), 64'(lat + 2));
      exp_h = sha_comp(ini ? IV : exp_h, blk_of());
      exp_cnt++;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic [31:0] w3_orig;
      int          k;
      int          starts;
      avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
      reset = 1'b1;
      exp_h = '0; exp_cnt = 0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst readdata", 64'(avs_readdata), 64'd0);
      check("rst irq", 64'(irq), 64'd0);
      check("rst core_start", 64'(core_start), 64'd0);
      check("rst core_init", 64'(core_init), 64'd0);
      check("rst core_block", 64'(core_block != '0), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      rd_chk("rst CTRL", 5'h10, 32'h0);
      rd_chk("rst STATUS", 5'h11, 32'h0);
      rd_chk("rst CNT", 5'h1A, 32'h0);
      rd_chk("rst H0", 5'h12, 32'h0);
      rd_chk("rst W5", 5'h05, 32'h0);

      // message buffer read-back and unmapped addresses
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
      load_msg();
      for (int i = 0; i < 16; i++) rd_chk($sformatf("msg W%0d", i), 5'(i), cur_msg[i]);
      check("core_block map", 64'(core_block == blk_of()), 64'd1);
      bus_wr(5'h1B, $urandom);
      for (int a = 5'h1B; a <= 5'h1F; a++) rd_chk($sformatf("unmapped 0x%0h", a), 5'(a), 32'h0);

      // "abc" single block
      for (int i = 0; i < 16; i++) cur_msg[i] = '0;
      cur_msg[0]  = 32'h61626380;
      cur_msg[15] = 32'h00000018;
      bus_wr(5'h1A, 32'h0);
      exp_cnt = 0;
      run_ok("abc", 1'b1, 3);
      rd_chk("abc H0 const", 5'h12, 32'hBA7816BF);
      rd_chk("abc H7 const", 5'h19, 32'hF20015AD);
      chk_digest("abc", exp_h);
      rd_chk("abc STATUS", 5'h11, 32'h2);
      rd_chk("abc CNT", 5'h1A, 32'd1);
      rd_chk("abc CTRL init cleared", 5'h10, 32'h4);
      check("abc core_init", 64'(init_log.pop_back()), 64'd1);

      // two-block message, chaining through core_init = 0
      bus_wr(5'h1A, 32'h0);
      exp_cnt = 0;
      init_log.delete();
      for (int i = 0; i < 14; i++) begin
         logic [7:0] c;
         c = 8'h61 + 8'(i);
         cur_msg[i] = {c, c + 8'd1, c + 8'd2, c + 8'd3};
      end
      cur_msg[14] = 32'h80000000;
      cur_msg[15] = 32'h0;
      run_ok("2blk b1", 1'b1, 5);
      for (int i = 0; i < 15; i++) cur_msg[i] = '0;
      cur_msg[15] = 32'h000001C0;
      run_ok("2blk b2", 1'b0, 7);
      rd_chk("2blk H0 const", 5'h12, 32'h248D6A61);
      rd_chk("2blk H7 const", 5'h19, 32'h19DB06C1);
      chk_digest("2blk", exp_h);
      rd_chk("2blk CNT", 5'h1A, 32'd2);
      check("2blk init log size", 64'(init_log.size()), 64'd2);
      if (init_log.size() == 2) begin
         check("2blk core_init b1", 64'(init_log[0]), 64'd1);
         check("2blk core_init b2", 64'(init_log[1]), 64'd0);
      end

      // random blocks, random chaining and latency
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
         run_ok($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
         chk_digest($sformatf("rnd%0d", n), exp_h);
         rd_chk($sformatf("rnd%0d CNT", n), 5'h1A, 32'(exp_cnt));
      end

      // core_done while IDLE is ignored
      inj_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      rd_chk("idle done STATUS", 5'h11, 32'h2);
      rd_chk("idle done H0", 5'h12, exp_h[255:224]);
      rd_chk("idle done CNT", 5'h1A, 32'(exp_cnt));

      // core_done during START is ignored
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
      core_lat = 5;
      clr_status();
      load_msg();
      start_blk(1'b1);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      wait_irq(30, k);
      check("start done latency", 64'(k + 1), 64'(5 + 2));
      exp_h = sha_comp(IV, blk_of());
      exp_cnt++;
      chk_digest("start done", exp_h);

      // MSG and START writes while busy are dropped and flag ERR
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
      w3_orig = cur_msg[3];
      core_lat = 10;
      clr_status();
      load_msg();
      starts = start_seen;
      start_blk(1'b1);
      @(negedge clk);
      bus_wr(5'h03, 32'hDEADBEEF);
      bus_wr(5'h10, 32'h7);
      rd_chk("busy STATUS", 5'h11, 32'h5);
      check("busy core_block W3", 64'(core_block[415:384]), 64'(w3_orig));
      wait_done("busy done", 30);
      exp_h = sha_comp(IV, blk_of());
      exp_cnt++;
      rd_chk("busy W3 kept", 5'h03, w3_orig);
      check("busy single start", 64'(start_seen - starts), 64'd1);
      rd_chk("busy STATUS end", 5'h11, 32'h6);
      chk_digest("busy", exp_h);
      clr_status();
      rd_chk("w1c both STATUS", 5'h11, 32'h0);
      check("w1c both irq", 64'(irq), 64'd0);

      // W1C DONE in the CAPTURE cycle: set wins
      core_lat = 6;
      start_blk(1'b1);
      repeat (6 + 1) @(negedge clk);
      bus_wr(5'h11, 32'h2);
      rd_chk("cap w1c STATUS", 5'h11, 32'h2);
      check("cap w1c irq before", 64'(irq), 64'd1);
      bus_wr(5'h11, 32'h2);
      check("cap w1c irq after", 64'(irq), 64'd0);
      exp_h = sha_comp(IV, blk_of());
      exp_cnt++;

      // STATUS read during CAPTURE returns pre-capture state
      start_blk(1'b1);
      repeat (6 + 1) @(negedge clk);
      rd_chk("cap rd STATUS", 5'h11, 32'h1);
      rd_chk("cap rd STATUS next", 5'h11, 32'h2);
      exp_h = sha_comp(IV, blk_of());
      exp_cnt++;

      // watchdog: core never answers; ERR after exactly TMO WAIT cycles
      core_hang = 1'b1;
      clr_status();
      start_blk(1'b1);
      repeat (TMO - 1) @(negedge clk);
      check("tmo irq k15", 64'(irq), 64'd0);
      @(negedge clk);
      check("tmo irq k16", 64'(irq), 64'd0);
      bus_wr(5'h11, 32'h4);
      check("tmo err set wins", 64'(irq), 64'd1);
      rd_chk("tmo STATUS", 5'h11, 32'h4);
      chk_digest("tmo", exp_h);
      rd_chk("tmo CNT", 5'h1A, 32'(exp_cnt));
      bus_wr(5'h10, 32'h0);
      check("tmo irq masked", 64'(irq), 64'd0);
      bus_wr(5'h10, 32'h4);
      core_hang = 1'b0;
      repeat (4) @(negedge clk);

      // done on the last permitted WAIT cycle wins over the timeout
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
      run_ok("edge16", 1'b1, TMO);
      rd_chk("edge16 STATUS", 5'h11, 32'h2);
      chk_digest("edge16", exp_h);

      // done one cycle too late is ignored and ERR is raised
      clr_status();
      core_lat = TMO + 1;
      start_blk(1'b1);
      repeat (TMO + 10) @(negedge clk);
      rd_chk("late STATUS", 5'h11, 32'h4);
      rd_chk("late H0", 5'h12, exp_h[255:224]);
      rd_chk("late CNT", 5'h1A, 32'(exp_cnt));

      // reset during WAIT, then the core answers
      clr_status();
      core_lat = 10;
      start_blk(1'b1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst wait readdata", 64'(avs_readdata), 64'd0);
      check("rst wait core_start", 64'(core_start), 64'd0);
      check("rst wait irq", 64'(irq), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      rd_chk("rst wait STATUS", 5'h11, 32'h0);
      rd_chk("rst wait CTRL", 5'h10, 32'h0);
      rd_chk("rst wait CNT", 5'h1A, 32'h0);
      rd_chk("rst wait H0", 5'h12, 32'h0);
      rd_chk("rst wait H7", 5'h19, 32'h0);
      rd_chk("rst wait W0", 5'h00, 32'h0);
      check("rst wait core_block", 64'(core_block != '0), 64'd0);
      check("rst wait irq end", 64'(irq), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
